xadc_drp_arbiter: RTL
=====================

XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum WAIT-state cycles before abort; only used when XADC_DRP_TIMEOUT_EN is defined; legal range 1..1023.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port DCLK  in  1  DRP and system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-005 SHALL have port REQ_VALID  in  2  per-requester transaction request; bit 0 is the config writer, bit 1 is the sample poller.
REQ-006 SHALL have port REQ_WE  in  2  per-requester write flag; 1 is write, 0 is read.
REQ-007 SHALL have port REQ_ADDR  in  14  per-requester DRP address; [6:0] is requester 0, [13:7] is requester 1.
REQ-008 SHALL have port REQ_DI  in  32  per-requester write data; [15:0] is requester 0, [31:16] is requester 1.
REQ-009 SHALL have port REQ_ACK  out  2  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port RD_DATA  out  16  last read result.
REQ-011 SHALL have port ERR  out  1  timeout flag, pulsed together with REQ_ACK.
REQ-012 SHALL have ports DADDR  out  7, DEN  out  1, DWE  out  1, DI  out  16: DRP request side to the XADC primitive.
REQ-013 SHALL have ports DO  in  16 and DRDY  in  1: DRP response side from the XADC primitive.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-015 IDLE SHALL stay in IDLE if REQ_VALID==0; otherwise it SHALL grant one requester, latch its WE/ADDR/DI into DWE/DADDR/DI, and go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; a lone requester is always granted.
REQ-017 ISSUE SHALL assert DEN=1 (and DWE=latched WE) for exactly one cycle, then go to WAIT.
REQ-018 DEN and DWE SHALL be 0 in every state except ISSUE; DADDR and DI SHALL hold their latched values until the next grant.
REQ-019 WAIT SHALL go to DONE on DRDY=1; for a read, RD_DATA SHALL load DO on that edge; for a write, RD_DATA SHALL be unchanged.
REQ-020 DONE SHALL assert REQ_ACK[grant]=1 for exactly one cycle, then go to IDLE.
REQ-021 Latency SHALL be: grant edge N, DEN high in cycle N+1, REQ_ACK high in the cycle after the edge that samples DRDY.
REQ-022 A requester SHALL hold VALID/WE/ADDR/DI stable until it sees its ACK and SHALL drop VALID on the edge ending the ACK cycle; REQ_VALID SHALL be sampled only in IDLE.
REQ-023 DRDY SHALL be ignored in IDLE, ISSUE and DONE.
REQ-024 Changes to REQ_* of the non-granted requester SHALL have no effect mid-transaction.

Reset
REQ-025 RESET_N=0 SHALL, asynchronously: set FSM=IDLE; set DEN, DWE, REQ_ACK, ERR=0; set DADDR=0, DI=0, RD_DATA=0; clear the timeout counter; set the round-robin pointer so requester 0 wins the first tie.
REQ-026 Reset during ISSUE or WAIT SHALL drop the transaction with no ACK; a late DRDY after release SHALL be ignored.

Configuration
REQ-027 With XADC_DRP_TIMEOUT_EN defined: a 10-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without DRDY, the FSM SHALL go to DONE with ERR=1 for the ACK cycle and RD_DATA unchanged.
REQ-028 Without XADC_DRP_TIMEOUT_EN: no counter SHALL be present, WAIT SHALL wait indefinitely for DRDY, and ERR SHALL be tied 0.

Verification
REQ-029 Read: REQ_VALID=01, REQ_ADDR[6:0]=0x00, REQ_WE=0, DRDY 3 cycles after DEN with DO=0x9A30 -> single DEN pulse with DADDR=0x00 and DWE=0; REQ_ACK=01 for one cycle; RD_DATA=0x9A30; ERR=0.
REQ-030 Write: REQ_VALID=10, REQ_ADDR[13:7]=0x40, REQ_DI[31:16]=0x03FF, REQ_WE=10 -> DEN=DWE=1 for one cycle with DI=0x03FF; REQ_ACK=10; RD_DATA unchanged.
REQ-031 Tie: REQ_VALID=11 held after reset, each requester dropping VALID on ACK then reasserting -> grant order 0,1,0,1; never two DEN pulses without an intervening DRDY.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=16): no DRDY -> REQ_ACK and ERR=1 together, 16 cycles after WAIT entry; FSM then returns to IDLE. With macro off: no ACK after 2000 cycles.
REQ-033 Reset in WAIT: RESET_N low 2 cycles, then DRDY=1 with DO=0x1234 -> all outputs 0 immediately; no ACK; RD_DATA stays 0; FSM in IDLE.

Source files
------------

// File: rtl/xadc_drp_arbiter.sv
// xadc_drp_arbiter: two-requester round-robin arbiter in front of the XADC DRP port.
// Requester 0 is the config writer, requester 1 is the sample poller.
// Optional build macro XADC_DRP_TIMEOUT_EN adds a WAIT-state timeout that
// completes the transaction with ERR=1 after TIMEOUT_CYCLES cycles without DRDY.
//
// state | meaning
// IDLE  | no transaction; sample REQ_VALID and grant
// ISSUE | DEN (and DWE for writes) high for this one cycle
// WAIT  | waiting for DRDY (or timeout when enabled)
// DONE  | REQ_ACK pulse to the granted requester
module xadc_drp_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        DCLK,
  input  logic        RESET_N,
  input  logic [1:0]  REQ_VALID,
  input  logic [1:0]  REQ_WE,
  input  logic [13:0] REQ_ADDR,
  input  logic [31:0] REQ_DI,
  output logic [1:0]  REQ_ACK,
  output logic [15:0] RD_DATA,
  output logic        ERR,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_param_check
    $error("TIMEOUT_CYCLES out of range 1..1023");
  end

  state_t      state_q;
  logic        gnt_q;
  logic        we_q;
  logic        den_q;
  logic        dwe_q;
  logic [6:0]  daddr_q;
  logic [15:0] di_q;
  logic [15:0] rd_data_q;
  logic [1:0]  ack_q;

  logic        gnt_d;
  logic        we_d;
  logic [6:0]  addr_d;
  logic [15:0] di_d;

`ifdef XADC_DRP_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CYCLES);
  logic [9:0] tmo_cnt_q;
  logic       err_q;
`endif

  // Round-robin pick: gnt_q doubles as the "last granted" pointer, so a tie
  // goes to the other requester; a lone requester always wins.
  always_comb begin
    gnt_d = REQ_VALID[1];
    if (REQ_VALID == 2'b11) begin
      gnt_d = ~gnt_q;
    end
    we_d   = gnt_d ? REQ_WE[1]       : REQ_WE[0];
    addr_d = gnt_d ? REQ_ADDR[13:7]  : REQ_ADDR[6:0];
    di_d   = gnt_d ? REQ_DI[31:16]   : REQ_DI[15:0];
  end

  // Transaction FSM with registered DRP and handshake outputs.
  always_ff @(posedge DCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b1;
      we_q      <= 1'b0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
      rd_data_q <= '0;
      ack_q     <= '0;
`ifdef XADC_DRP_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID != 2'b00) begin
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            daddr_q <= addr_d;
            di_q    <= di_d;
            den_q   <= 1'b1;
            dwe_q   <= we_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          den_q   <= 1'b0;
          dwe_q   <= 1'b0;
`ifdef XADC_DRP_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (DRDY) begin
            if (!we_q) begin
              rd_data_q <= DO;
            end
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            state_q <= DONE;
          end
`ifdef XADC_DRP_TIMEOUT_EN
          else if (tmo_cnt_q + 10'd1 == TMO_LIMIT) begin
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 10'd1;
          end
`endif
        end
        DONE: begin
          ack_q   <= 2'b00;
`ifdef XADC_DRP_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_ACK = ack_q;
  assign RD_DATA = rd_data_q;
  assign DADDR   = daddr_q;
  assign DEN     = den_q;
  assign DWE     = dwe_q;
  assign DI      = di_q;

`ifdef XADC_DRP_TIMEOUT_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
